// File: rtl/alu_pkg.sv
// Shared definitions for the simple_alu command path.
//   WIDTH_DEF / OPW_DEF : default operand and opcode widths
//   alu_state_e         : command driver FSM states
//   alu_cmd_t           : command layout at default widths {opcode, a, b}
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned OPW_DEF   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StOpA,
    StOpB,
    StWait,
    StResp
  } alu_state_e;

  typedef struct packed {
    logic [OPW_DEF-1:0]   opcode;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered storage (no fall-through).
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en/wr_data: push, ignored while full
//   rd_en/rd_data: pop, rd_data shows the head entry, ignored while empty
//   full, empty  : status from the pointers
module alu_cmd_fifo #(
  parameter int unsigned DW    = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_wr, do_rd;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command stage in front of simple_alu. Buffers {opcode, a, b} commands, drives
// them onto the ALU pins (opcode+a, then b), waits for done under a watchdog and
// returns the result on a valid/ready response port.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          : command handshake; cmd_opcode, cmd_a, cmd_b
//   opcode_valid, opcode, data   : ALU issue pins (registered)
//   done, result, overflow       : ALU completion
//   rsp_valid/rsp_ready          : response handshake; rsp_result, rsp_overflow,
//                                  rsp_timeout (registered)
//   busy                         : FSM active or commands queued
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned OPW     = OPW_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             opcode_valid,
  output logic [OPW-1:0]   opcode,
  output logic [WIDTH-1:0] data,
  input  logic             done,
  input  logic [WIDTH-1:0] result,
  input  logic             overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WdogLast = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_entry_t;

  cmd_entry_t       wr_entry, head;
  logic             fifo_full, fifo_empty, fifo_pop;
  alu_state_e       state_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    wdog_q;

  assign wr_entry  = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign busy      = (state_q != StIdle) || !fifo_empty;

  alu_cmd_fifo #(
    .DW    ($bits(cmd_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (cmd_valid),
    .wr_data (wr_entry),
    .rd_en   (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ALU pin values are set on the transition into each state so they line up
  // with the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      b_q          <= '0;
      wdog_q       <= '0;
      opcode_valid <= 1'b0;
      opcode       <= '0;
      data         <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      opcode_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            b_q          <= head.b;
            opcode_valid <= 1'b1;
            opcode       <= head.opcode;
            data         <= head.a;
            state_q      <= StOpA;
          end
        end
        StOpA: begin
          data    <= b_q;
          wdog_q  <= '0;
          state_q <= StOpB;
        end
        StOpB: begin
          data    <= '0;
          wdog_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // done takes priority over a simultaneous watchdog expiry
          if (done) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= result;
            rsp_overflow <= overflow;
            rsp_timeout  <= 1'b0;
            state_q      <= StResp;
          end else if (wdog_q == WdogLast) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b1;
            state_q      <= StResp;
          end else begin
            wdog_q <= wdog_q + CW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_opcode;
  logic [7:0] cmd_a, cmd_b;
  logic       opcode_valid;
  logic [1:0] opcode;
  logic [7:0] data;
  logic       done;
  logic [7:0] result;
  logic       overflow;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_overflow, rsp_timeout, busy;

  // ALU stub (automatic) plus manual done injection from the main sequence
  logic       alu_en;
  int         alu_delay;
  logic       alu_done, man_done;
  logic [7:0] alu_result, man_result;
  logic       alu_ovf, man_ovf;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] fa   [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
  logic [7:0] fb   [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  logic [7:0] fexp [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] got  [6];

  assign done     = alu_done | man_done;
  assign result   = man_done ? man_result : alu_result;
  assign overflow = man_done ? man_ovf : alu_ovf;

  always #5 clk = ~clk;

  alu_cmd_driver #(
    .WIDTH   (8),
    .OPW     (2),
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .opcode_valid (opcode_valid),
    .opcode       (opcode),
    .data         (data),
    .done         (done),
    .result       (result),
    .overflow     (overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_total++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n          = 0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_opv(output int cyc);
    cyc = 0;
    while (!opcode_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("opv_seen", 32'(opcode_valid), 32'd1);
  endtask

  initial begin : alu_model
    logic [1:0] m_op;
    logic [7:0] m_a, m_b;
    logic [8:0] sum;
    alu_done   = 1'b0;
    alu_result = '0;
    alu_ovf    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && alu_en && opcode_valid) begin
        m_op = opcode;
        m_a  = data;
        @(posedge clk);
        #1;
        m_b = data;
        repeat (alu_delay) @(posedge clk);
        #1;
        case (m_op)
          2'd0: begin sum = {1'b0, m_a} + {1'b0, m_b}; alu_result = sum[7:0]; alu_ovf = sum[8]; end
          2'd1: begin sum = {1'b0, m_a} - {1'b0, m_b}; alu_result = sum[7:0]; alu_ovf = sum[8]; end
          2'd2: begin alu_result = m_a & m_b; alu_ovf = 1'b0; end
          default: begin alu_result = m_a ^ m_b; alu_ovf = 1'b0; end
        endcase
        alu_done = 1'b1;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got=stuck exp=finish");
    $fatal(1);
  end

  initial begin : main
    int c, acc, nr, cnt;
    logic go;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    rsp_ready  = 1'b1;
    alu_en     = 1'b1;
    alu_delay  = 2;
    man_done   = 1'b0;
    man_result = '0;
    man_ovf    = 1'b0;
    for (int i = 0; i < 6; i++) got[i] = '0;

    // Reset values
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_opv", 32'(opcode_valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single command: 05 + 03
    send(2'd0, 8'h05, 8'h03);
    check("single_idle_opv", 32'(opcode_valid), 32'd0);
    tick();
    check("single_opa_opv", 32'(opcode_valid), 32'd1);
    check("single_opa_data", 32'(data), 32'h05);
    check("single_opa_opcode", 32'(opcode), 32'd0);
    tick();
    check("single_opb_opv", 32'(opcode_valid), 32'd0);
    check("single_opb_data", 32'(data), 32'h03);
    wait_rsp(c);
    check("single_rsp_lat", 32'(c), 32'd3);
    check("single_result", 32'(rsp_result), 32'h08);
    check("single_ovf", 32'(rsp_overflow), 32'd0);
    check("single_to", 32'(rsp_timeout), 32'd0);
    tick();
    check("single_rsp_drop", 32'(rsp_valid), 32'd0);
    check("single_busy", 32'(busy), 32'd0);

    // Overflow pass-through: F0 + 20
    send(2'd0, 8'hF0, 8'h20);
    wait_rsp(c);
    check("ovf_result", 32'(rsp_result), 32'h10);
    check("ovf_flag", 32'(rsp_overflow), 32'd1);
    check("ovf_to", 32'(rsp_timeout), 32'd0);
    tick();

    // Timeout: ALU silent
    alu_en = 1'b0;
    send(2'd1, 8'h09, 8'h04);
    wait_opv(c);
    tick();
    wait_rsp(c);
    check("to_latency", 32'(c), 32'd17);
    check("to_flag", 32'(rsp_timeout), 32'd1);
    check("to_result", 32'(rsp_result), 32'd0);
    check("to_ovf", 32'(rsp_overflow), 32'd0);
    tick();
    alu_en = 1'b1;
    send(2'd2, 8'hCC, 8'hAA);
    wait_rsp(c);
    check("after_to_result", 32'(rsp_result), 32'h88);
    check("after_to_flag", 32'(rsp_timeout), 32'd0);
    tick();

    // Spurious done in IDLE and OP_A, then done on the expiry cycle
    alu_en     = 1'b0;
    man_done   = 1'b1;
    man_result = 8'h55;
    tick();
    man_done = 1'b0;
    repeat (3) tick();
    check("spur_idle_rsp", 32'(rsp_valid), 32'd0);
    check("spur_idle_busy", 32'(busy), 32'd0);
    send(2'd3, 8'h0F, 8'hFF);
    wait_opv(c);
    man_done   = 1'b1;
    man_result = 8'h99;
    tick();
    man_done = 1'b0;
    check("spur_opa_rsp", 32'(rsp_valid), 32'd0);
    repeat (16) tick();
    check("coinc_pre_rsp", 32'(rsp_valid), 32'd0);
    man_done   = 1'b1;
    man_result = 8'hF0;
    tick();
    man_done = 1'b0;
    check("coinc_valid", 32'(rsp_valid), 32'd1);
    check("coinc_to", 32'(rsp_timeout), 32'd0);
    check("coinc_result", 32'(rsp_result), 32'hF0);
    tick();

    // Fill and stall
    alu_en    = 1'b1;
    rsp_ready = 1'b0;
    acc       = 0;
    for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
      cmd_valid  = 1'b1;
      cmd_opcode = 2'd0;
      cmd_a      = fa[acc];
      cmd_b      = fb[acc];
      go         = cmd_ready;
      tick();
      if (go) acc++;
    end
    cmd_a = fa[5];
    cmd_b = fb[5];
    repeat (10) begin
      if (cmd_ready) acc++;
      tick();
    end
    check("fill_accepts", 32'(acc), 32'd5);
    check("fill_ready_low", 32'(cmd_ready), 32'd0);
    check("fill_busy", 32'(busy), 32'd1);
    check("fill_rsp_held", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    nr        = 0;
    for (int cyc = 0; cyc < 300 && nr < 6; cyc++) begin
      if (rsp_valid) begin
        got[nr] = rsp_result;
        nr++;
      end
      go = cmd_valid && cmd_ready;
      tick();
      if (go) cmd_valid = 1'b0;
    end
    check("fill_rsp_count", 32'(nr), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("fill_rsp%0d", i), 32'(got[i]), 32'(fexp[i]));
    tick();
    check("fill_end_busy", 32'(busy), 32'd0);

    // Reset during WAIT with two commands queued
    alu_en = 1'b0;
    send(2'd0, 8'h01, 8'h01);
    send(2'd0, 8'h02, 8'h02);
    send(2'd0, 8'h03, 8'h03);
    repeat (3) tick();
    check("mid_busy", 32'(busy), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_result", 32'(rsp_result), 32'd0);
    check("mid_rst_opv", 32'(opcode_valid), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    man_done   = 1'b1;
    man_result = 8'h77;
    tick();
    man_done = 1'b0;
    cnt      = 0;
    repeat (20) begin
      if (rsp_valid || opcode_valid) cnt++;
      tick();
    end
    check("late_done_rsp", 32'(cnt), 32'd0);
    check("late_done_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
